// File: rtl/i2s_sample_fifo.sv
// Stereo sample FIFO feeding an I2S serializer: valid/ready push side, one held
// pair per load strobe, prefill gating and underrun muting to silence.
module i2s_sample_fifo #(
  parameter int unsigned DW      = 24,
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned AW      = $clog2(DEPTH),
  parameter int unsigned PREFILL = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_l,
  input  logic [DW-1:0] in_r,
  input  logic          load,
  output logic [DW-1:0] l_data,
  output logic [DW-1:0] r_data,
  output logic [AW:0]   level,
  output logic          running,
  output logic [7:0]    underrun_cnt,
  input  logic          clr_stats
);

  typedef enum logic [0:0] {StPrefill, StRun} state_e;

  localparam logic [AW:0] FullLvl    = (AW+1)'(DEPTH);
  localparam logic [AW:0] PrefillLvl = (AW+1)'(PREFILL);
  localparam logic [AW:0] PtrOne     = (AW+1)'(1);

  logic [2*DW-1:0] mem_q [DEPTH];
  logic [AW:0]     wr_ptr_q, wr_ptr_d;
  logic [AW:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]     level_w;
  logic [2*DW-1:0] out_q, out_d;
  logic [7:0]      urun_q, urun_d;
  state_e          state_q, state_d;
  logic            push;

  // Pointers carry one extra wrap bit so full and empty stay distinguishable.
  assign level_w  = wr_ptr_q - rd_ptr_q;
  assign in_ready = reset & (level_w != FullLvl);
  assign push     = in_valid & in_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    out_d    = out_q;
    urun_d   = urun_q;
    state_d  = state_q;

    if (push) wr_ptr_d = wr_ptr_q + PtrOne;

    unique case (state_q)
      StPrefill: begin
        if (load) out_d = '0;
        if (level_w >= PrefillLvl) state_d = StRun;
      end
      StRun: begin
        if (load) begin
          if (level_w != '0) begin
            out_d    = mem_q[rd_ptr_q[AW-1:0]];
            rd_ptr_d = rd_ptr_q + PtrOne;
          end else begin
            // Underrun: mute and re-prefill rather than replay stale data.
            out_d   = '0;
            state_d = StPrefill;
            if (urun_q != 8'hFF) urun_d = urun_q + 8'd1;
          end
        end
      end
      default: state_d = StPrefill;
    endcase

    if (clr_stats) urun_d = '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      out_q    <= '0;
      urun_q   <= '0;
      state_q  <= StPrefill;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      out_q    <= out_d;
      urun_q   <= urun_d;
      state_q  <= state_d;
    end
  end

  // Storage needs no reset: pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= {in_l, in_r};
  end

  assign l_data       = out_q[2*DW-1:DW];
  assign r_data       = out_q[DW-1:0];
  assign level        = level_w;
  assign running      = (state_q == StRun);
  assign underrun_cnt = urun_q;

endmodule

// File: tb/tb_i2s_sample_fifo.sv
// Directed bench for i2s_sample_fifo: prefill, full/wrap ordering, underrun
// saturation and clear, same-edge push/pop, async reset mid-traffic.
module tb_i2s_sample_fifo;

  localparam int unsigned DW = 24;
  localparam int unsigned AW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_l;
  logic [DW-1:0] in_r;
  logic          load;
  logic [DW-1:0] l_data;
  logic [DW-1:0] r_data;
  logic [AW:0]   level;
  logic          running;
  logic [7:0]    underrun_cnt;
  logic          clr_stats;

  int tests_run    = 0;
  int tests_failed = 0;

  i2s_sample_fifo #(
    .DW      (24),
    .DEPTH   (16),
    .AW      (4),
    .PREFILL (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_l         (in_l),
    .in_r         (in_r),
    .load         (load),
    .l_data       (l_data),
    .r_data       (r_data),
    .level        (level),
    .running      (running),
    .underrun_cnt (underrun_cnt),
    .clr_stats    (clr_stats)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_pair(input logic [DW-1:0] l, input logic [DW-1:0] r);
    in_valid = 1'b1;
    in_l     = l;
    in_r     = r;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic pulse_load();
    load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  task automatic push_and_load(input logic [DW-1:0] l, input logic [DW-1:0] r);
    in_valid = 1'b1;
    in_l     = l;
    in_r     = r;
    load     = 1'b1;
    tick();
    in_valid = 1'b0;
    load     = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_l      = '0;
    in_r      = '0;
    load      = 1'b0;
    clr_stats = 1'b0;
    #1 reset  = 1'b0;
    tick();
    check_val("rst_in_ready", in_ready, 0);
    check_val("rst_level", level, 0);
    check_val("rst_running", running, 0);
    check_val("rst_l_data", l_data, 0);
    check_val("rst_cnt", underrun_cnt, 0);
    reset = 1'b1;
    tick();
    check_val("rel_in_ready", in_ready, 1);

    // Prefill gating
    for (int i = 0; i < 3; i++) push_pair(24'h000011 + 24'(i), 24'hFFFF01 + 24'(i));
    check_val("pf_level3", level, 3);
    pulse_load();
    pulse_load();
    check_val("pf_l_zero", l_data, 0);
    check_val("pf_r_zero", r_data, 0);
    check_val("pf_not_run", running, 0);
    push_pair(24'h000014, 24'hFFFF04);
    tick();
    check_val("pf_run", running, 1);
    pulse_load();
    check_val("pf_pop1_l", l_data, 24'h000011);
    check_val("pf_pop1_r", r_data, 24'hFFFF01);
    pulse_load();
    check_val("pf_pop2_l", l_data, 24'h000012);
    check_val("pf_pop2_r", r_data, 24'hFFFF02);
    pulse_load();
    pulse_load();
    check_val("pf_pop4_l", l_data, 24'h000014);
    check_val("pf_empty", level, 0);

    // First underrun
    pulse_load();
    check_val("ur1_l", l_data, 0);
    check_val("ur1_r", r_data, 0);
    check_val("ur1_cnt", underrun_cnt, 1);
    check_val("ur1_run", running, 0);

    // Full, overflow ignored, drain order across pointer wrap
    for (int i = 0; i < 16; i++) push_pair(24'hA00000 + 24'(i), 24'h500000 + 24'(i));
    check_val("full_level", level, 16);
    check_val("full_ready", in_ready, 0);
    push_pair(24'hBADBAD, 24'hBADBAD);
    check_val("full_ignored", level, 16);
    for (int i = 0; i < 16; i++) begin
      pulse_load();
      check_val($sformatf("drain_l%0d", i), l_data, 24'hA00000 + 24'(i));
      check_val($sformatf("drain_r%0d", i), r_data, 24'h500000 + 24'(i));
    end
    check_val("drain_empty", level, 0);
    check_val("drain_run", running, 1);

    // Same-edge push and pop at level 5
    for (int i = 0; i < 5; i++) push_pair(24'hC00000 + 24'(i), 24'h300000 + 24'(i));
    check_val("sim_level5", level, 5);
    push_and_load(24'hDDDDDD, 24'h111111);
    check_val("sim_level_kept", level, 5);
    check_val("sim_oldest_l", l_data, 24'hC00000);
    check_val("sim_oldest_r", r_data, 24'h300000);
    for (int i = 0; i < 5; i++) pulse_load();
    check_val("sim_last_l", l_data, 24'hDDDDDD);
    check_val("sim_last_r", r_data, 24'h111111);
    check_val("sim_empty", level, 0);

    // Push into empty on the load edge: underrun, pair kept
    push_and_load(24'h123456, 24'h654321);
    check_val("pe_cnt", underrun_cnt, 2);
    check_val("pe_level", level, 1);
    check_val("pe_run", running, 0);
    check_val("pe_l_zero", l_data, 0);
    for (int i = 0; i < 3; i++) push_pair(24'h0000E0 + 24'(i), 24'h0000F0 + 24'(i));
    tick();
    pulse_load();
    check_val("pe_kept_l", l_data, 24'h123456);
    check_val("pe_kept_r", r_data, 24'h654321);
    for (int i = 0; i < 3; i++) pulse_load();
    pulse_load();
    check_val("ur3_cnt", underrun_cnt, 3);

    // Saturation
    for (int n = 0; n < 300; n++) begin
      for (int i = 0; i < 4; i++) push_pair(24'(n), 24'(i));
      tick();
      for (int i = 0; i < 5; i++) pulse_load();
    end
    check_val("sat_cnt", underrun_cnt, 255);
    check_val("sat_run", running, 0);
    clr_stats = 1'b1;
    tick();
    clr_stats = 1'b0;
    check_val("clr_cnt", underrun_cnt, 0);

    // Clear wins over a same-edge underrun increment
    for (int i = 0; i < 4; i++) push_pair(24'h00AA00, 24'h00BB00);
    tick();
    for (int i = 0; i < 4; i++) pulse_load();
    clr_stats = 1'b1;
    pulse_load();
    clr_stats = 1'b0;
    check_val("clr_wins_cnt", underrun_cnt, 0);
    check_val("clr_wins_run", running, 0);

    // Async reset mid-traffic
    pulse_load();
    for (int i = 0; i < 4; i++) push_pair(24'h0F0F0F, 24'h070707);
    tick();
    for (int i = 0; i < 4; i++) pulse_load();
    pulse_load();
    push_pair(24'h777777, 24'h888888);
    for (int i = 0; i < 3; i++) push_pair(24'h999999, 24'hAAAAAA);
    tick();
    pulse_load();
    check_val("pre_rst_l", l_data, 24'h777777);
    check_val("pre_rst_cnt", underrun_cnt, 1);
    in_valid = 1'b1;
    in_l     = 24'h555555;
    in_r     = 24'h666666;
    #2 reset = 1'b0;
    #1;
    check_val("arst_l", l_data, 0);
    check_val("arst_r", r_data, 0);
    check_val("arst_level", level, 0);
    check_val("arst_run", running, 0);
    check_val("arst_cnt", underrun_cnt, 0);
    check_val("arst_ready", in_ready, 0);
    tick();
    in_valid = 1'b0;
    check_val("arst_hold_level", level, 0);
    reset = 1'b1;
    tick();
    check_val("arst_rel_ready", in_ready, 1);
    check_val("arst_rel_level", level, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
